// File: rtl/mux_pipe.sv
// Purpose: pipelined radix-2 lane mux, selects one DW-bit lane of MW packed lanes.
// Latency: L = ceil(log2(MW)/RL) cycles from input handshake to out_vld.
// Backpressure: valid/ready per stage; bubbles collapse, in_rdy falls only when all L stages hold data.
module mux_pipe #(
  parameter int DW = 4,
  parameter int MW = 4,
  parameter int RL = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DW*MW-1:0]        inp,
  input  logic [$clog2(MW)-1:0]   sel,
  input  logic                    in_vld,
  output logic                    in_rdy,
  output logic [DW-1:0]           out,
  output logic                    out_vld,
  input  logic                    out_rdy
);

  localparam int SW = $clog2(MW);
  localparam int LV = SW;
  localparam int L  = (LV + RL - 1) / RL;
  localparam int NP = 1 << LV;

  // Stage boundaries: index 0 is the input port, index s+1 is the output register of stage s.
  // Nodes are kept at full tree width; nodes above the live range of a level are zero.
  // Selector bits are shifted right as levels are consumed, so bit 0 always drives the next level.
  logic [NP-1:0][DW-1:0] nd [0:L];
  logic [SW-1:0]         sl [0:L];
  logic                  vq [0:L];
  logic [L:0]            en;
  logic [NP-1:0][DW-1:0] lanes;

  // Zero-pad the lane vector up to a power of two so out-of-range selects resolve to 0.
  for (genvar i = 0; i < NP; i++) begin : g_lane
    if (i < MW) begin : g_real
      assign lanes[i] = inp[DW*i +: DW];
    end else begin : g_pad
      assign lanes[i] = '0;
    end
  end

  assign nd[0] = lanes;
  assign sl[0] = sel;
  assign vq[0] = in_vld;

  // Load enables ripple back from the sink: a stage moves when it is empty or its successor moves.
  always_comb begin
    en    = '0;
    en[L] = out_rdy;
    for (int s = L - 1; s >= 0; s--) begin
      en[s] = !vq[s+1] | en[s+1];
    end
  end

  assign in_rdy = en[0];

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int LO   = s * RL;
    localparam int NLEV = ((s + 1) * RL > LV) ? (LV - LO) : RL;

    logic [NP-1:0][DW-1:0] red;
    logic [SW-1:0]         sl_nxt;
    logic [NP-1:0][DW-1:0] d_q;
    logic [SW-1:0]         s_q;
    logic                  v_q;

    // Reduce this stage's tree levels in place: node k takes node 2k or 2k+1.
    always_comb begin
      red = nd[s];
      for (int m = 0; m < NLEV; m++) begin
        for (int k = 0; k < NP / 2; k++) begin
          red[k] = sl[s][m] ? red[2*k+1] : red[2*k];
        end
        for (int k = NP / 2; k < NP; k++) begin
          red[k] = '0;
        end
      end
      sl_nxt = sl[s] >> NLEV;
    end

    // Stage register: loads surviving nodes, remaining select bits and valid when enabled.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        d_q <= '0;
        s_q <= '0;
        v_q <= 1'b0;
      end else if (en[s]) begin
        d_q <= red;
        s_q <= sl_nxt;
        v_q <= vq[s];
      end
    end

    assign nd[s+1] = d_q;
    assign sl[s+1] = s_q;
    assign vq[s+1] = v_q;
  end

  assign out     = nd[L][0];
  assign out_vld = vq[L];

  // Upper nodes and exhausted select bits of the last stage carry no information.
  logic unused_tail;
  assign unused_tail = ^{nd[L][NP-1:1], sl[L]};

endmodule

// File: tb/tb_mux_pipe.sv
// Purpose: scoreboard bench for mux_pipe, two configs (MW=4/RL=1 and MW=5/RL=2), directed vectors.
// Latency: both configs have L=2; latency checked on unstalled items.
// Backpressure: stalls, full-pipe hold, random valid/ready and mid-stream reset exercised.
module tb_mux_pipe;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Config A: DW=8, MW=4, RL=1
  logic [31:0] a_inp = '0;
  logic [1:0]  a_sel = '0;
  logic        a_in_vld = 1'b0;
  logic        a_in_rdy;
  logic [7:0]  a_out;
  logic        a_out_vld;
  logic        a_out_rdy = 1'b1;

  // Config B: DW=8, MW=5, RL=2
  logic [39:0] b_inp = '0;
  logic [2:0]  b_sel = '0;
  logic        b_in_vld = 1'b0;
  logic        b_in_rdy;
  logic [7:0]  b_out;
  logic        b_out_vld;
  logic        b_out_rdy = 1'b1;

  mux_pipe #(.DW(8), .MW(4), .RL(1)) u_a (
    .clk(clk), .rstn(rstn), .inp(a_inp), .sel(a_sel), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
    .out(a_out), .out_vld(a_out_vld), .out_rdy(a_out_rdy)
  );

  mux_pipe #(.DW(8), .MW(5), .RL(2)) u_b (
    .clk(clk), .rstn(rstn), .inp(b_inp), .sel(b_sel), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .out(b_out), .out_vld(b_out_vld), .out_rdy(b_out_rdy)
  );

  typedef struct {
    logic [7:0] d;
    int         t;
    bit         lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int a_hs = 0;
  int a_rdy_low = 0;
  int max_occ_a = 0;

  logic [7:0] a_exp = '0;
  bit         a_lat = 1'b0;
  logic [7:0] b_exp = '0;
  bit         b_lat = 1'b0;

  // Hand-computed vectors for config A: lane i = inp[8*i +: 8].
  logic [31:0] tv_d [0:7] = '{32'h44332211, 32'h44332211, 32'h44332211, 32'h44332211,
                              32'hDEADBEEF, 32'hDEADBEEF, 32'h0F1E2D3C, 32'hA5C3967E};
  logic [1:0]  tv_s [0:7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2};
  logic [7:0]  tv_e [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hBE, 8'hDE, 8'h3C, 8'hC3};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, need %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor + recorder for A: compare presented output with queue head, push on input handshake.
  always @(negedge clk) begin
    if (rstn) begin
      if (qa.size() > max_occ_a) max_occ_a = qa.size();
      if (a_out_vld) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL a_spurious: got output %0h, need none", a_out);
        end else begin
          check("a_data", a_out, qa[0].d);
          if (a_out_rdy) begin
            if (qa[0].lat) check("a_latency", cyc - qa[0].t, 2);
            void'(qa.pop_front());
          end
        end
      end
      if (a_in_vld && !a_in_rdy) a_rdy_low++;
      if (a_in_vld && a_in_rdy) begin
        qa.push_back('{a_exp, cyc, a_lat});
        a_hs++;
      end
    end
  end

  // Monitor + recorder for B.
  always @(negedge clk) begin
    if (rstn) begin
      if (b_out_vld) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_spurious: got output %0h, need none", b_out);
        end else begin
          check("b_data", b_out, qb[0].d);
          if (b_out_rdy) begin
            if (qb[0].lat) check("b_latency", cyc - qb[0].t, 2);
            void'(qb.pop_front());
          end
        end
      end
      if (b_in_vld && b_in_rdy) qb.push_back('{b_exp, cyc, b_lat});
    end
  end

  task automatic send_a(input logic [31:0] d, input logic [1:0] s, input logic [7:0] e, input bit lat);
    a_inp = d; a_sel = s; a_exp = e; a_lat = lat; a_in_vld = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_in_rdy) begin
        @(posedge clk); #1;
        a_in_vld = 1'b0;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL a_send_timeout: got no in_rdy in 100 cycles, need accept");
    @(posedge clk); #1;
    a_in_vld = 1'b0;
  endtask

  task automatic send_b(input logic [39:0] d, input logic [2:0] s, input logic [7:0] e);
    b_inp = d; b_sel = s; b_exp = e; b_lat = 1'b1; b_in_vld = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_in_rdy) begin
        @(posedge clk); #1;
        b_in_vld = 1'b0;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL b_send_timeout: got no in_rdy in 100 cycles, need accept");
    @(posedge clk); #1;
    b_in_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    a_out_rdy = 1'b1;
    b_out_rdy = 1'b1;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int hs0;
    bit took;
    int k;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_a_out_vld", a_out_vld, 0);
    check("rst_a_in_rdy", a_in_rdy, 1);
    check("rst_a_out", a_out, 0);
    check("rst_b_out_vld", b_out_vld, 0);
    check("rst_b_in_rdy", b_in_rdy, 1);
    check("rst_b_out", b_out, 0);
    @(posedge clk); #1;

    // Single item, sel=2 -> 0x33 after 2 cycles
    send_a(32'h44332211, 2'd2, 8'h33, 1'b1);
    drain();

    // Back-to-back sel 0..3, in_rdy must never drop
    a_rdy_low = 0;
    for (int i = 0; i < 4; i++) send_a(tv_d[i], tv_s[i], tv_e[i], 1'b1);
    drain();
    check("a_b2b_rdy_low", a_rdy_low, 0);

    // Non-power-of-two config: lane 4 real, selects 5..7 are padding
    send_b(40'h5544332211, 3'd4, 8'h55);
    send_b(40'h5544332211, 3'd6, 8'h00);
    send_b(40'h5544332211, 3'd5, 8'h00);
    send_b(40'h5544332211, 3'd3, 8'h44);
    send_b(40'hA1B2C3D4E5, 3'd7, 8'h00);
    send_b(40'hA1B2C3D4E5, 3'd0, 8'hE5);
    drain();

    // Stall: pipe fills with L items, in_rdy drops, head output holds
    a_out_rdy = 1'b0;
    hs0 = a_hs;
    send_a(tv_d[0], tv_s[0], tv_e[0], 1'b0);
    send_a(tv_d[4], tv_s[4], tv_e[4], 1'b0);
    a_inp = tv_d[7]; a_sel = tv_s[7]; a_exp = tv_e[7]; a_lat = 1'b0; a_in_vld = 1'b1;
    repeat (5) @(negedge clk);
    check("a_full_in_rdy", a_in_rdy, 0);
    check("a_full_accepted", a_hs - hs0, 2);
    check("a_full_out_vld", a_out_vld, 1);
    @(posedge clk); #1;
    a_out_rdy = 1'b1;
    send_a(tv_d[7], tv_s[7], tv_e[7], 1'b0);
    drain();

    // Random valid/ready against the scoreboard
    took = 1'b0;
    max_occ_a = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      if (took) a_in_vld = 1'b0;
      if (!a_in_vld && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, 7);
        a_inp = tv_d[k]; a_sel = tv_s[k]; a_exp = tv_e[k]; a_lat = 1'b0;
        a_in_vld = 1'b1;
      end
      a_out_rdy = (c < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      @(negedge clk);
      took = a_in_vld && a_in_rdy;
    end
    @(posedge clk); #1;
    if (took) a_in_vld = 1'b0;
    a_in_vld = 1'b0;
    drain();
    n_cmp++;
    if (max_occ_a > 2) begin
      n_bad++;
      $display("FAIL a_occupancy: got %0d, need at most 2", max_occ_a);
    end

    // Mid-stream reset with 2 items in flight
    send_a(tv_d[1], tv_s[1], tv_e[1], 1'b1);
    send_a(tv_d[2], tv_s[2], tv_e[2], 1'b1);
    rstn = 1'b0;
    #1;
    check("a_rst_mid_out_vld", a_out_vld, 0);
    check("a_rst_mid_in_rdy", a_in_rdy, 1);
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_a(tv_d[6], tv_s[6], tv_e[6], 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
